// File: rtl/regfile_pkg.sv
// Shared constants and the packed-slice helper for the multi-port register file.
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_ADDR_W = 5;

    // Low bit of field idx inside a vector of equal-width packed fields
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/regfile_wr_sel.sv
// Next-value selection for one register entry: highest-index hitting write port wins.
module regfile_wr_sel
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned ENTRY  = 0
) (
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0]        o_data_c,
    output logic                     o_hit_c,
    output logic                     o_multi_c
);

    // Ascending scan so a later (higher-index) port overrides earlier ones
    always_comb begin
        o_data_c  = '0;
        o_hit_c   = 1'b0;
        o_multi_c = 1'b0;
        for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (i_wr_en[k] && (i_wr_addr[slice_lo(k, ADDR_W) +: ADDR_W] == ADDR_W'(ENTRY))) begin
                o_multi_c = o_multi_c | o_hit_c;
                o_hit_c   = 1'b1;
                o_data_c  = i_wr_data[slice_lo(k, DATA_W) +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with busy scoreboard and write-collision flag.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DEFAULT_DATA_W,
    parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_WR-1:0]        wr_en_i,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
    input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     busy_set_i,
    input  logic [ADDR_W-1:0]        busy_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    output logic                     wr_conflict_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic              r_conflict;

    logic [DATA_W-1:0] w_nxt [DEPTH];
    logic [DEPTH-1:0]  w_hit;
    logic [DEPTH-1:0]  w_multi;
    logic [DEPTH-1:0]  w_we;
    logic [DEPTH-1:0]  w_set;
    logic [ADDR_W-1:0] w_ra;

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        localparam bit IS_ZERO = (ZERO_REG != 0) && (e == 0);

        regfile_wr_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR),
            .ENTRY  (e)
        ) u_wr_sel (
            .i_wr_en   (wr_en_i),
            .i_wr_addr (wr_addr_i),
            .i_wr_data (wr_data_i),
            .o_data_c  (w_nxt[e]),
            .o_hit_c   (w_hit[e]),
            .o_multi_c (w_multi[e])
        );

        assign w_we[e]  = w_hit[e] & ~IS_ZERO;
        assign w_set[e] = busy_set_i && (busy_addr_i == ADDR_W'(e)) && !IS_ZERO;
    end

    // Storage, scoreboard (set beats clear) and one-cycle collision flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
            r_busy     <= '0;
            r_conflict <= 1'b0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (w_we[e]) begin
                    r_mem[e] <= w_nxt[e];
                end
            end
            r_busy     <= (r_busy & ~w_we) | w_set;
            r_conflict <= |(w_multi & w_we);
        end
    end

    // Combinational read ports
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = '0;
        w_ra      = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            w_ra = rd_addr_i[slice_lo(p, ADDR_W) +: ADDR_W];
            rd_data_o[slice_lo(p, DATA_W) +: DATA_W] = r_mem[w_ra];
            rd_busy_o[p] = r_busy[w_ra];
`ifdef REGFILE_BYPASS_EN
            for (int unsigned k = 0; k < NUM_WR; k++) begin
                if (!rst_i && wr_en_i[k]
                    && (wr_addr_i[slice_lo(k, ADDR_W) +: ADDR_W] == w_ra)
                    && !((ZERO_REG != 0) && (w_ra == '0))) begin
                    rd_data_o[slice_lo(p, DATA_W) +: DATA_W] = wr_data_i[slice_lo(k, DATA_W) +: DATA_W];
                    rd_busy_o[p] = 1'b0;
                end
            end
`endif
        end
    end

    assign wr_conflict_o = r_conflict;

endmodule
